mc_exec_unit: RTL and testbench

Parametrised multicycle execute unit for the multicycle RISC-V core. It accepts one operation command through a valid/ready handshake. It then sequences register read, ALU execute and register write-back over fixed cycles using an internal FSM, and returns the result through a valid/ready response. It replaces the hand-wired register-file/extend/operand-mux/ALU cluster with one self-sequencing block of configurable width and depth.

---
 rtl/mc_pkg.sv | 39 +++
 rtl/mc_alu.sv | 41 ++++
 rtl/mc_exec_unit.sv | 173 +++++++++++++++++
 tb/tb_mc_exec_unit.sv | 316 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mc_pkg.sv
// Shared types and constants for the multicycle execute unit.
package mc_pkg;

    typedef enum logic [2:0] {
        ALU_ADD = 3'd0,
        ALU_SUB = 3'd1,
        ALU_AND = 3'd2,
        ALU_OR  = 3'd3,
        ALU_XOR = 3'd4,
        ALU_SLT = 3'd5,
        ALU_SLL = 3'd6,
        ALU_SRL = 3'd7
    } alu_op_e;

    typedef enum logic [1:0] {
        SRCA_PC    = 2'd0,
        SRCA_OLDPC = 2'd1,
        SRCA_RS1   = 2'd2,
        SRCA_ZERO  = 2'd3
    } srca_e;

    typedef enum logic [1:0] {
        SRCB_RS2  = 2'd0,
        SRCB_IMM  = 2'd1,
        SRCB_FOUR = 2'd2,
        SRCB_ZERO = 2'd3
    } srcb_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        READ = 2'd1,
        EXEC = 2'd2,
        WB   = 2'd3
    } state_e;

    // Increment used for PC+4 style operations.
    localparam int CONST_FOUR = 4;

endpackage

// File: rtl/mc_alu.sv
// Combinational ALU: eight operations, shift amounts masked to log2(XLEN) bits.
module mc_alu
    import mc_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    input  alu_op_e         op,
    output logic [XLEN-1:0] result,
    output logic            zero
);

    localparam int SHW = $clog2(XLEN);

    logic [SHW-1:0] shamt;
    logic           less;

    assign shamt = b[SHW-1:0];
    assign less  = $signed(a) < $signed(b);

    // Select the operation result.
    always_comb begin
        // NOTE: default assigned first so no path through the case infers a latch.
        result = '0;
        case (op)
            ALU_ADD: result = a + b;
            ALU_SUB: result = a - b;
            ALU_AND: result = a & b;
            ALU_OR:  result = a | b;
            ALU_XOR: result = a ^ b;
            ALU_SLT: result = {{(XLEN-1){1'b0}}, less};
            ALU_SLL: result = a << shamt;
            ALU_SRL: result = a >> shamt;
            default: result = '0;
        endcase
    end

    assign zero = (result == '0);

endmodule

// File: rtl/mc_exec_unit.sv
// Self-sequencing execute unit: command latch, register file, operand muxes,
// ALU and write-back, driven by a READ/EXEC/WB FSM with a 3-cycle latency.
module mc_exec_unit
    import mc_pkg::*;
#(
    parameter  int XLEN  = 32,
    parameter  int NREG  = 32,
    parameter  int IMM_W = 12,
    localparam int RW    = $clog2(NREG)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [RW-1:0]    cmd_rs1,
    input  logic [RW-1:0]    cmd_rs2,
    input  logic [RW-1:0]    cmd_rd,
    input  logic [IMM_W-1:0] cmd_imm,
    input  logic [1:0]       cmd_srca,
    input  logic [1:0]       cmd_srcb,
    input  logic [2:0]       cmd_aluop,
    input  logic             cmd_we,
    input  logic [XLEN-1:0]  pc_in,
    input  logic [XLEN-1:0]  oldpc_in,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [XLEN-1:0]  rsp_result,
    output logic             rsp_zero
);

    state_e            state, state_next;
    logic              exec_done;   // second EXEC cycle: ALU result is being committed

    logic [RW-1:0]     rs1_q, rs2_q, rd_q;
    logic [IMM_W-1:0]  imm_q;
    srca_e             srca_q;
    srcb_e             srcb_q;
    alu_op_e           op_q;
    logic              we_q;
    logic [XLEN-1:0]   pc_q, oldpc_q;

    logic [XLEN-1:0]   regs [NREG];
    logic [XLEN-1:0]   rs1_data, rs2_data, imm_ext;
    logic [XLEN-1:0]   a_data, b_data, op_a, op_b, src_a, src_b;
    logic [XLEN-1:0]   r_q, alu_result;
    logic              z_q, alu_zero, wb_write;

    // State register plus the EXEC sub-cycle flag.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            exec_done <= 1'b0;
        end else begin
            // NOTE: sequential state uses <= so every flop samples pre-edge values.
            state     <= state_next;
            exec_done <= (state == EXEC) && !exec_done;
        end
    end

    // Next-state and handshake outputs.
    always_comb begin
        state_next = state;
        cmd_ready  = 1'b0;
        rsp_valid  = 1'b0;
        case (state)
            IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid) state_next = READ;
            end
            READ: state_next = EXEC;
            EXEC: if (exec_done) state_next = WB;
            WB: begin
                rsp_valid = 1'b1;
                if (rsp_ready) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Capture the command and PC values at accept; ignored afterwards.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rs1_q   <= '0;
            rs2_q   <= '0;
            rd_q    <= '0;
            imm_q   <= '0;
            srca_q  <= SRCA_PC;
            srcb_q  <= SRCB_RS2;
            op_q    <= ALU_ADD;
            we_q    <= 1'b0;
            pc_q    <= '0;
            oldpc_q <= '0;
        end else if (state == IDLE && cmd_valid) begin
            rs1_q   <= cmd_rs1;
            rs2_q   <= cmd_rs2;
            rd_q    <= cmd_rd;
            imm_q   <= cmd_imm;
            srca_q  <= srca_e'(cmd_srca);
            srcb_q  <= srcb_e'(cmd_srcb);
            op_q    <= alu_op_e'(cmd_aluop);
            we_q    <= cmd_we;
            pc_q    <= pc_in;
            oldpc_q <= oldpc_in;
        end
    end

    assign rs1_data = (rs1_q == '0) ? '0 : regs[rs1_q];
    assign rs2_data = (rs2_q == '0) ? '0 : regs[rs2_q];
    assign imm_ext  = XLEN'($signed(imm_q));

    // Operand selection from the latched source codes.
    always_comb begin
        src_a = '0;
        src_b = '0;
        case (srca_q)
            SRCA_PC:    src_a = pc_q;
            SRCA_OLDPC: src_a = oldpc_q;
            SRCA_RS1:   src_a = a_data;
            default:    src_a = '0;
        endcase
        case (srcb_q)
            SRCB_RS2:  src_b = b_data;
            SRCB_IMM:  src_b = imm_ext;
            SRCB_FOUR: src_b = XLEN'(CONST_FOUR);
            default:   src_b = '0;
        endcase
    end

    mc_alu #(.XLEN(XLEN)) u_alu (
        .a      (op_a),
        .b      (op_b),
        .op     (op_q),
        .result (alu_result),
        .zero   (alu_zero)
    );

    // Datapath pipeline: register read, muxed operands, then result/zero on WB entry.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            a_data <= '0;
            b_data <= '0;
            op_a   <= '0;
            op_b   <= '0;
            r_q    <= '0;
            z_q    <= 1'b1;
        end else if (state == READ) begin
            a_data <= rs1_data;
            b_data <= rs2_data;
        end else if (state == EXEC && !exec_done) begin
            op_a   <= src_a;
            op_b   <= src_b;
        end else if (state == EXEC && exec_done) begin
            r_q    <= alu_result;
            z_q    <= alu_zero;
        end
    end

    assign wb_write = (state == EXEC) && exec_done && we_q && (rd_q != '0);

    // Register file: one write per command, committed on the edge that enters WB.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            // NOTE: the array is reset because a reset must leave every register reading 0.
            for (int i = 0; i < NREG; i++) regs[i] <= '0;
        end else if (wb_write) begin
            regs[rd_q] <= alu_result;
        end
    end

    assign rsp_result = r_q;
    assign rsp_zero   = z_q;

endmodule

// File: tb/tb_mc_exec_unit.sv
// Self-checking bench: directed steps plus randomized commands for a 32-bit
// and a 16-bit instance, checked against an arithmetic reference model.
module tb_mc_exec_unit;

    typedef struct packed {
        logic [4:0]  rs1, rs2, rd;
        logic [11:0] imm;
        logic [1:0]  srca, srcb;
        logic [2:0]  op;
        logic        we;
        logic [31:0] pc, oldpc;
    } cmd_t;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    // Instance 0: XLEN=32, NREG=32
    logic        c1_valid, c1_ready, c1_we, r1_valid, r1_ready, r1_zero;
    logic [4:0]  c1_rs1, c1_rs2, c1_rd;
    logic [11:0] c1_imm;
    logic [1:0]  c1_srca, c1_srcb;
    logic [2:0]  c1_op;
    logic [31:0] c1_pc, c1_oldpc, r1_result;

    // Instance 1: XLEN=16, NREG=8
    logic        c2_valid, c2_ready, c2_we, r2_valid, r2_ready, r2_zero;
    logic [2:0]  c2_rs1, c2_rs2, c2_rd;
    logic [11:0] c2_imm;
    logic [1:0]  c2_srca, c2_srcb;
    logic [2:0]  c2_op;
    logic [15:0] c2_pc, c2_oldpc, r2_result;

    mc_exec_unit #(.XLEN(32), .NREG(32), .IMM_W(12)) dut32 (
        .clk(clk), .reset(reset), .cmd_valid(c1_valid), .cmd_ready(c1_ready),
        .cmd_rs1(c1_rs1), .cmd_rs2(c1_rs2), .cmd_rd(c1_rd), .cmd_imm(c1_imm),
        .cmd_srca(c1_srca), .cmd_srcb(c1_srcb), .cmd_aluop(c1_op), .cmd_we(c1_we),
        .pc_in(c1_pc), .oldpc_in(c1_oldpc), .rsp_valid(r1_valid), .rsp_ready(r1_ready),
        .rsp_result(r1_result), .rsp_zero(r1_zero)
    );

    mc_exec_unit #(.XLEN(16), .NREG(8), .IMM_W(12)) dut16 (
        .clk(clk), .reset(reset), .cmd_valid(c2_valid), .cmd_ready(c2_ready),
        .cmd_rs1(c2_rs1), .cmd_rs2(c2_rs2), .cmd_rd(c2_rd), .cmd_imm(c2_imm),
        .cmd_srca(c2_srca), .cmd_srcb(c2_srcb), .cmd_aluop(c2_op), .cmd_we(c2_we),
        .pc_in(c2_pc), .oldpc_in(c2_oldpc), .rsp_valid(r2_valid), .rsp_ready(r2_ready),
        .rsp_result(r2_result), .rsp_zero(r2_zero)
    );

    int          n_asserts = 0;
    int          n_fails   = 0;
    logic [31:0] mreg [2][32];   // architectural register model per instance
    logic [31:0] m_res;
    logic        m_zero;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic int xlen_of(input int which);
        return (which != 0) ? 16 : 32;
    endfunction

    function automatic logic [31:0] mask_of(input int which);
        return (which != 0) ? 32'h0000_FFFF : 32'hFFFF_FFFF;
    endfunction

    function automatic int ridx(input int which, input logic [4:0] r);
        return (which != 0) ? int'(r[2:0]) : int'(r);
    endfunction

    function automatic logic [31:0] sext(input int which, input logic [11:0] imm);
        longint v;
        v = imm[11] ? longint'(imm) - 4096 : longint'(imm);
        return 32'(v) & mask_of(which);
    endfunction

    function automatic logic [31:0] ref_alu(input int which, input logic [2:0] op,
                                            input logic [31:0] a, input logic [31:0] b);
        int     xl;
        longint ua, ub, sa, sb, r;
        int     sh;
        xl = xlen_of(which);
        ua = longint'(a);
        ub = longint'(b);
        sa = a[xl-1] ? ua - (longint'(1) << xl) : ua;
        sb = b[xl-1] ? ub - (longint'(1) << xl) : ub;
        sh = int'(ub % xl);
        case (op)
            3'd0: r = ua + ub;
            3'd1: r = ua - ub;
            3'd2: r = ua & ub;
            3'd3: r = ua | ub;
            3'd4: r = ua ^ ub;
            3'd5: r = (sa < sb) ? 1 : 0;
            3'd6: r = ua << sh;
            default: r = ua >> sh;
        endcase
        return 32'(r) & mask_of(which);
    endfunction

    function automatic cmd_t mk(input logic [1:0] srca, input logic [1:0] srcb,
                                input logic [2:0] op, input logic [4:0] rs1,
                                input logic [4:0] rs2, input logic [4:0] rd,
                                input logic [11:0] imm, input logic we);
        cmd_t c;
        c.srca = srca; c.srcb = srcb; c.op = op;
        c.rs1 = rs1; c.rs2 = rs2; c.rd = rd; c.imm = imm; c.we = we;
        c.pc = $urandom; c.oldpc = $urandom;
        return c;
    endfunction

    // ---------------- DUT access ----------------
    task automatic drive(input int which, input cmd_t c, input logic v);
        if (which == 0) begin
            c1_valid = v; c1_rs1 = c.rs1; c1_rs2 = c.rs2; c1_rd = c.rd; c1_imm = c.imm;
            c1_srca = c.srca; c1_srcb = c.srcb; c1_op = c.op; c1_we = c.we;
            c1_pc = c.pc; c1_oldpc = c.oldpc;
        end else begin
            c2_valid = v; c2_rs1 = c.rs1[2:0]; c2_rs2 = c.rs2[2:0]; c2_rd = c.rd[2:0];
            c2_imm = c.imm; c2_srca = c.srca; c2_srcb = c.srcb; c2_op = c.op; c2_we = c.we;
            c2_pc = c.pc[15:0]; c2_oldpc = c.oldpc[15:0];
        end
    endtask

    function automatic logic [31:0] o_result(input int which);
        return (which != 0) ? {16'h0, r2_result} : r1_result;
    endfunction
    function automatic logic o_valid(input int which);
        return (which != 0) ? r2_valid : r1_valid;
    endfunction
    function automatic logic o_zero(input int which);
        return (which != 0) ? r2_zero : r1_zero;
    endfunction
    function automatic logic o_ready(input int which);
        return (which != 0) ? c2_ready : c1_ready;
    endfunction

    task automatic set_rsp_ready(input int which, input logic v);
        if (which == 0) r1_ready = v; else r2_ready = v;
    endtask

    // Present a command, predict its outcome, and return just after the accept edge.
    task automatic send(input int which, input cmd_t c);
        logic [31:0] a, b;
        int          n;
        case (c.srca)
            2'd0: a = c.pc & mask_of(which);
            2'd1: a = c.oldpc & mask_of(which);
            2'd2: a = mreg[which][ridx(which, c.rs1)];
            default: a = 32'h0;
        endcase
        case (c.srcb)
            2'd0: b = mreg[which][ridx(which, c.rs2)];
            2'd1: b = sext(which, c.imm);
            2'd2: b = 32'd4;
            default: b = 32'h0;
        endcase
        m_res  = ref_alu(which, c.op, a, b);
        m_zero = (m_res == 32'h0);
        if (c.we && ridx(which, c.rd) != 0) mreg[which][ridx(which, c.rd)] = m_res;

        @(negedge clk);
        drive(which, c, 1'b1);
        n = 0;
        while (!o_ready(which) && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) check("accept_timeout", 32'(o_ready(which)), 32'd1);
        @(posedge clk);
        #1;
        c.pc = $urandom;
        c.oldpc = $urandom;
        drive(which, c, 1'b0);
    endtask

    // Count cycles to rsp_valid from the accept edge and check the response.
    task automatic await_rsp(input int which, input string tag,
                             input logic [31:0] exp_res, input logic exp_zero);
        int lat;
        lat = 0;
        do begin
            @(posedge clk);
            #1;
            lat++;
        end while (!o_valid(which) && lat < 20);
        check({tag, "_latency"}, 32'(lat), 32'd3);
        check({tag, "_result"}, o_result(which), exp_res);
        check({tag, "_zero"}, 32'(o_zero(which)), 32'(exp_zero));
    endtask

    task automatic release_rsp(input int which, input string tag);
        @(negedge clk);
        set_rsp_ready(which, 1'b1);
        @(posedge clk);
        #1;
        set_rsp_ready(which, 1'b0);
        check({tag, "_ready_after"}, 32'(o_ready(which)), 32'd1);
    endtask

    task automatic do_cmd(input int which, input cmd_t c, input string tag,
                          input logic [31:0] exp_res, input logic exp_zero);
        send(which, c);
        await_rsp(which, tag, exp_res, exp_zero);
        release_rsp(which, tag);
    endtask

    task automatic clear_model();
        for (int w = 0; w < 2; w++)
            for (int i = 0; i < 32; i++) mreg[w][i] = 32'h0;
    endtask

    initial begin
        cmd_t c, c_next;

        clear_model();
        reset = 1'b1;
        drive(0, '0, 1'b0);
        drive(1, '0, 1'b0);
        r1_ready = 1'b0;
        r2_ready = 1'b0;

        // Reset state of both instances
        #23;
        for (int w = 0; w < 2; w++) begin
            check("reset_cmd_ready", 32'(o_ready(w)), 32'd1);
            check("reset_rsp_valid", 32'(o_valid(w)), 32'd0);
            check("reset_rsp_zero",  32'(o_zero(w)),  32'd1);
            check("reset_rsp_result", o_result(w),    32'h0);
        end
        @(negedge clk);
        reset = 1'b0;

        // Directed steps on the 32-bit instance
        do_cmd(0, mk(2'd2, 2'd0, 3'd0, 5'd5, 5'd7, 5'd0, 12'd0, 1'b0), "add_zero_regs", 32'h0, 1'b1);
        do_cmd(0, mk(2'd3, 2'd1, 3'd0, 5'd0, 5'd0, 5'd2, 12'd30, 1'b1), "li_30", 32'd30, 1'b0);
        c = mk(2'd1, 2'd2, 3'd0, 5'd0, 5'd0, 5'd0, 12'd0, 1'b0);
        c.oldpc = 32'd4;
        do_cmd(0, c, "oldpc_plus4", 32'd8, 1'b0);
        do_cmd(0, mk(2'd2, 2'd1, 3'd0, 5'd2, 5'd0, 5'd3, 12'hFFF, 1'b1), "addi_neg1", 32'd29, 1'b0);
        do_cmd(0, mk(2'd2, 2'd0, 3'd1, 5'd3, 5'd2, 5'd0, 12'd0, 1'b0), "sub_neg", 32'hFFFF_FFFF, 1'b0);
        do_cmd(0, mk(2'd2, 2'd0, 3'd1, 5'd2, 5'd2, 5'd0, 12'd0, 1'b0), "sub_self", 32'h0, 1'b1);
        do_cmd(0, mk(2'd3, 2'd1, 3'd0, 5'd0, 5'd0, 5'd0, 12'd5, 1'b1), "write_x0", 32'd5, 1'b0);
        do_cmd(0, mk(2'd2, 2'd3, 3'd0, 5'd0, 5'd0, 5'd0, 12'd0, 1'b0), "read_x0", 32'h0, 1'b1);
        do_cmd(0, mk(2'd3, 2'd1, 3'd0, 5'd0, 5'd0, 5'd5, 12'hFFF, 1'b1), "li_m1", 32'hFFFF_FFFF, 1'b0);
        do_cmd(0, mk(2'd3, 2'd1, 3'd0, 5'd0, 5'd0, 5'd6, 12'd1, 1'b1), "li_1", 32'd1, 1'b0);
        do_cmd(0, mk(2'd2, 2'd0, 3'd5, 5'd5, 5'd6, 5'd0, 12'd0, 1'b0), "slt_m1_1", 32'd1, 1'b0);
        do_cmd(0, mk(2'd2, 2'd1, 3'd6, 5'd6, 5'd0, 5'd7, 12'd31, 1'b1), "sll_msb", 32'h8000_0000, 1'b0);
        do_cmd(0, mk(2'd3, 2'd1, 3'd0, 5'd0, 5'd0, 5'd9, 12'd33, 1'b1), "li_33", 32'd33, 1'b0);
        do_cmd(0, mk(2'd2, 2'd0, 3'd7, 5'd7, 5'd9, 5'd0, 12'd0, 1'b0), "srl_masked", 32'h4000_0000, 1'b0);
        do_cmd(0, mk(2'd2, 2'd1, 3'd6, 5'd6, 5'd0, 5'd0, 12'd4, 1'b0), "sll_1_4", 32'd16, 1'b0);
        do_cmd(0, mk(2'd3, 2'd1, 3'd0, 5'd0, 5'd0, 5'd10, 12'hF0, 1'b1), "li_f0", 32'hF0, 1'b0);
        do_cmd(0, mk(2'd2, 2'd1, 3'd4, 5'd10, 5'd0, 5'd0, 12'hFF, 1'b0), "xor_f0_ff", 32'h0F, 1'b0);

        // Back-pressure: response held, a pending command is not taken
        send(0, mk(2'd2, 2'd1, 3'd0, 5'd2, 5'd0, 5'd11, 12'd12, 1'b1));
        await_rsp(0, "bp_first", 32'd42, 1'b0);
        c_next = mk(2'd2, 2'd1, 3'd0, 5'd11, 5'd0, 5'd12, 12'd1, 1'b1);
        @(negedge clk);
        drive(0, c_next, 1'b1);
        repeat (5) begin
            @(posedge clk);
            #1;
            check("bp_valid_held",  32'(r1_valid), 32'd1);
            check("bp_result_held", r1_result, 32'd42);
            check("bp_zero_held",   32'(r1_zero), 32'd0);
            check("bp_cmd_ready",   32'(c1_ready), 32'd0);
        end
        release_rsp(0, "bp_release");
        do_cmd(0, c_next, "bp_next", 32'd43, 1'b0);

        // Reset in the middle of EXEC drops the write to x4
        send(0, mk(2'd3, 2'd1, 3'd0, 5'd0, 5'd0, 5'd4, 12'd77, 1'b1));
        @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        check("midreset_rsp_valid", 32'(r1_valid), 32'd0);
        check("midreset_cmd_ready", 32'(c1_ready), 32'd1);
        check("midreset_rsp_zero",  32'(r1_zero), 32'd1);
        clear_model();
        @(negedge clk);
        reset = 1'b0;
        do_cmd(0, mk(2'd2, 2'd3, 3'd0, 5'd4, 5'd0, 5'd0, 12'd0, 1'b0), "x4_after_reset", 32'h0, 1'b1);
        do_cmd(0, mk(2'd2, 2'd3, 3'd0, 5'd2, 5'd0, 5'd0, 12'd0, 1'b0), "x2_after_reset", 32'h0, 1'b1);

        // 16-bit instance: sign extension to 16 bits and wrap-around
        do_cmd(1, mk(2'd3, 2'd1, 3'd0, 5'd0, 5'd0, 5'd1, 12'hFFF, 1'b1), "x16_li_m1", 32'hFFFF, 1'b0);
        do_cmd(1, mk(2'd2, 2'd1, 3'd0, 5'd1, 5'd0, 5'd2, 12'd1, 1'b1), "x16_wrap", 32'h0, 1'b1);

        // Randomized commands against the model
        for (int w = 0; w < 2; w++) begin
            for (int k = 0; k < 40; k++) begin
                c = mk(2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), 3'($urandom_range(0, 7)),
                       5'($urandom_range(0, (w != 0) ? 7 : 31)),
                       5'($urandom_range(0, (w != 0) ? 7 : 31)),
                       5'($urandom_range(0, (w != 0) ? 7 : 31)),
                       12'($urandom), 1'($urandom));
                send(w, c);
                await_rsp(w, "random", m_res, m_zero);
                repeat ($urandom_range(0, 2)) @(posedge clk);
                release_rsp(w, "random");
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fails);
        $finish;
    end

endmodule
